// File: rtl/wb_param_loader.sv
// wb_param_loader: Wishbone initiator that collects one neuron parameter
// record from a valid/ready word stream, writes it into the parameter
// register block, and optionally reads every word back to confirm it landed.
module wb_param_loader #(
    parameter logic [31:0] PARAM_BASE  = 32'h8002_0000,
    parameter int          NUM_WORDS   = 12,
    parameter int          ACK_TIMEOUT = 15
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        word_valid_i,
    input  logic [31:0] word_data_i,
    output logic        word_ready_o,
    input  logic        verify_i,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic        wbm_ack_i,
    input  logic [31:0] wbm_dat_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o,
    output logic [3:0]  err_idx_o
);

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WGAP,
        RD,
        RGAP,
        DONE
    } state_t;

    localparam logic [3:0]        LAST_IDX  = 4'(NUM_WORDS - 1);
    localparam int                WAIT_W    = $clog2(ACK_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ACK_TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [3:0]        idx_q, idx_d;
    logic              verify_q, verify_d;
    logic              error_q, error_d;
    logic [3:0]        errIdx_q, errIdx_d;
    logic [WAIT_W-1:0] waitCnt_q, waitCnt_d;
    logic [31:0]       buffer_q [NUM_WORDS];

    logic        wordReady;
    logic        wordHs;
    logic        busActive;
    logic [31:0] busAdr;

    // The loader only takes words while idle and never while reset is held,
    // so a word presented during reset is not silently swallowed.
    assign wordReady = (state_q == IDLE) && wb_rst_i;
    assign wordHs    = word_valid_i && wordReady;

    assign busActive = (state_q == WR) || (state_q == RD);
    assign busAdr    = PARAM_BASE + {26'd0, idx_q, 2'b00};

    assign word_ready_o = wordReady;
    assign wbm_cyc_o    = busActive;
    assign wbm_stb_o    = busActive;
    assign wbm_we_o     = (state_q == WR);
    assign wbm_sel_o    = busActive ? 4'hF : 4'h0;
    assign wbm_adr_o    = busActive ? busAdr : 32'd0;
    assign wbm_dat_o    = (state_q == WR) ? buffer_q[idx_q] : 32'd0;
    assign busy_o       = ((state_q != IDLE) && (state_q != DONE)) ||
                          ((state_q == IDLE) && (cnt_q != 4'd0));
    assign done_o       = (state_q == DONE);
    assign error_o      = error_q;
    assign err_idx_o    = errIdx_q;

    // Record buffer: each accepted stream word lands in the slot named by the fill count.
    always_ff @(posedge wb_clk_i) begin
        if (wordHs) begin
            buffer_q[cnt_q] <= word_data_i;
        end
    end

    // State and bookkeeping registers; reset returns to an empty, idle loader.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            idx_q     <= 4'd0;
            verify_q  <= 1'b0;
            error_q   <= 1'b0;
            errIdx_q  <= 4'd0;
            waitCnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            verify_q  <= verify_d;
            error_q   <= error_d;
            errIdx_q  <= errIdx_d;
            waitCnt_q <= waitCnt_d;
        end
    end

    // Next-state logic: fill, fire-and-forget writes with a gap, then optional acked readback.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        verify_d  = verify_q;
        error_d   = error_q;
        errIdx_d  = errIdx_q;
        waitCnt_d = waitCnt_q;

        case (state_q)
            IDLE: begin
                if (wordHs) begin
                    if (cnt_q == 4'd0) begin
                        error_d  = 1'b0;
                        errIdx_d = 4'd0;
                    end
                    if (cnt_q == LAST_IDX) begin
                        cnt_d    = 4'd0;
                        idx_d    = 4'd0;
                        verify_d = verify_i;
                        state_d  = WR;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end

            WR: begin
                state_d = WGAP;
            end

            WGAP: begin
                if (idx_q != LAST_IDX) begin
                    idx_d   = idx_q + 4'd1;
                    state_d = WR;
                end else if (verify_q) begin
                    idx_d     = 4'd0;
                    waitCnt_d = '0;
                    state_d   = RD;
                end else begin
                    state_d = DONE;
                end
            end

            RD: begin
                if (wbm_ack_i) begin
                    if ((wbm_dat_i != buffer_q[idx_q]) && !error_q) begin
                        error_d  = 1'b1;
                        errIdx_d = idx_q;
                    end
                    state_d = RGAP;
                end else if (waitCnt_q == WAIT_LAST) begin
                    if (!error_q) begin
                        error_d  = 1'b1;
                        errIdx_d = idx_q;
                    end
                    state_d = RGAP;
                end else begin
                    waitCnt_d = waitCnt_q + WAIT_W'(1);
                end
            end

            RGAP: begin
                if (!wbm_ack_i) begin
                    if (idx_q != LAST_IDX) begin
                        idx_d     = idx_q + 4'd1;
                        waitCnt_d = '0;
                        state_d   = RD;
                    end else begin
                        state_d = DONE;
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_wb_param_loader.sv
// tb_wb_param_loader: drives neuron parameter records into wb_param_loader
// against a small Wishbone slave that can corrupt or withhold read acks, and
// compares the bus traffic and status against a record-level model.
module tb_wb_param_loader;

    localparam logic [31:0] BASE    = 32'h8002_0000;
    localparam int          NUM     = 12;
    localparam int          TIMEOUT = 15;

    logic        wbClk = 1'b0;
    logic        wbRstN;
    logic        wordValid;
    logic [31:0] wordData;
    logic        wordReady;
    logic        verifyIn;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, datOut;
    logic        ack;
    logic [31:0] datIn;
    logic        busy, done, error;
    logic [3:0]  errIdx;

    int asrtCnt = 0;
    int failCnt = 0;

    logic [31:0] recData [NUM];
    int          noAckIdx;
    logic [15:0] corruptMask;
    bit          gotFirst;
    logic        errAfterFirst;
    logic [3:0]  errIdxAfterFirst;

    wb_param_loader #(
        .PARAM_BASE (BASE),
        .NUM_WORDS  (NUM),
        .ACK_TIMEOUT(TIMEOUT)
    ) dut (
        .wb_clk_i    (wbClk),
        .wb_rst_i    (wbRstN),
        .word_valid_i(wordValid),
        .word_data_i (wordData),
        .word_ready_o(wordReady),
        .verify_i    (verifyIn),
        .wbm_cyc_o   (cyc),
        .wbm_stb_o   (stb),
        .wbm_we_o    (we),
        .wbm_sel_o   (sel),
        .wbm_adr_o   (adr),
        .wbm_dat_o   (datOut),
        .wbm_ack_i   (ack),
        .wbm_dat_i   (datIn),
        .busy_o      (busy),
        .done_o      (done),
        .error_o     (error),
        .err_idx_o   (errIdx)
    );

    always #5 wbClk = ~wbClk;

    // Slave: stores writes, answers reads with a registered ack and data that
    // trail stb by one cycle, optionally flipping a bit or never acking a word.
    logic [31:0] slvMem [16];
    logic [3:0]  slvIdx;
    assign slvIdx = 4'((adr - BASE) >> 2);

    always @(posedge wbClk) begin
        if (cyc && stb && we) slvMem[slvIdx] <= datOut;
        ack   <= cyc && stb && !we && (int'(slvIdx) != noAckIdx);
        datIn <= slvMem[slvIdx] ^ (corruptMask[slvIdx] ? 32'h0000_0100 : 32'h0);
    end

    // Bus monitor: logs write/read transactions and protocol oddities each cycle.
    int          cycleCnt = 0;
    int          firstWr, doneCyc, doneCnt, acceptCnt, protoErr, readWhileAck, curLen;
    bit          prevRead, prevWrite;
    logic [31:0] wAdr [$];
    logic [31:0] wDat [$];
    logic [31:0] rAdr [$];
    int          rLen [$];

    always @(negedge wbClk) begin
        cycleCnt++;
        if (stb && we) begin
            wAdr.push_back(adr);
            wDat.push_back(datOut);
            if (firstWr < 0) firstWr = cycleCnt;
            if (prevWrite) protoErr++;
        end
        if (stb && !we) begin
            if (!prevRead) begin
                rAdr.push_back(adr);
                if (ack) readWhileAck++;
                curLen = 1;
            end else begin
                curLen++;
            end
        end else if (prevRead) begin
            rLen.push_back(curLen);
        end
        prevRead  = stb && !we;
        prevWrite = stb && we;
        if (cyc !== stb) protoErr++;
        if (stb && sel !== 4'hF) protoErr++;
        if (!stb && (we || sel != 4'h0 || adr != 32'd0 || datOut != 32'd0)) protoErr++;
        if (wordReady && (cyc || done)) protoErr++;
        if (busy && done) protoErr++;
        if (done) begin
            doneCnt++;
            doneCyc = cycleCnt;
        end
        if (wordValid && wordReady) acceptCnt++;
    end

    task automatic clearMon();
        wAdr.delete();
        wDat.delete();
        rAdr.delete();
        rLen.delete();
        firstWr      = -1;
        doneCyc      = -1;
        doneCnt      = 0;
        acceptCnt    = 0;
        protoErr     = 0;
        readWhileAck = 0;
        prevRead     = 1'b0;
        prevWrite    = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        asrtCnt++;
        assert (obs === exp)
        else begin
            failCnt++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference model: first word the readback should flag, or -1 when clean.
    function automatic int expErrIdx(input bit verify);
        if (!verify) return -1;
        for (int i = 0; i < NUM; i++)
            if (i == noAckIdx || corruptMask[i]) return i;
        return -1;
    endfunction

    // Reference model: cycles from the first write to done given this slave.
    function automatic int expLatency(input bit verify);
        int t = 2 * NUM;
        if (verify)
            for (int i = 0; i < NUM; i++) t += (i == noAckIdx) ? TIMEOUT + 1 : 4;
        return t;
    endfunction

    task automatic applyStimulus(input bit verify, input bit holdValid);
        int k = 0;
        int guard = 0;
        gotFirst  = 1'b0;
        verifyIn  = verify;
        wordValid = 1'b1;
        wordData  = recData[0];
        while (k < NUM && guard < 200) begin
            @(negedge wbClk);
            if (k == 1 && !gotFirst) begin
                errAfterFirst    = error;
                errIdxAfterFirst = errIdx;
                gotFirst         = 1'b1;
            end
            if (wordReady) k++;
            @(posedge wbClk);
            #1;
            if (k < NUM) wordData = recData[k];
            else if (!holdValid) wordValid = 1'b0;
            else wordData = $urandom;
            guard++;
        end
        checkOutput("words_accepted", 32'(k), 32'(NUM));
    endtask

    task automatic waitDone(input string tag);
        int n = 0;
        @(negedge wbClk);
        while (!done && n < 400) begin
            @(negedge wbClk);
            n++;
        end
        checkOutput(tag, 32'(done), 32'd1);
    endtask

    task automatic verifyBus(input bit verify);
        int e = expErrIdx(verify);
        checkOutput("write_count", 32'(wAdr.size()), 32'(NUM));
        for (int i = 0; i < NUM && i < wAdr.size(); i++) begin
            checkOutput($sformatf("write_adr[%0d]", i), wAdr[i], BASE + 32'(4 * i));
            checkOutput($sformatf("write_dat[%0d]", i), wDat[i], recData[i]);
        end
        checkOutput("read_count", 32'(rAdr.size()), verify ? 32'(NUM) : 32'd0);
        for (int i = 0; i < rAdr.size(); i++)
            checkOutput($sformatf("read_adr[%0d]", i), rAdr[i], BASE + 32'(4 * i));
        if (noAckIdx >= 0 && noAckIdx < rLen.size())
            checkOutput("timeout_len", 32'(rLen[noAckIdx]), 32'(TIMEOUT));
        checkOutput("done_latency", 32'(doneCyc - firstWr), 32'(expLatency(verify)));
        checkOutput("done_count", 32'(doneCnt), 32'd1);
        checkOutput("protocol", 32'(protoErr), 32'd0);
        checkOutput("read_while_ack", 32'(readWhileAck), 32'd0);
        checkOutput("error_sticky", 32'(error), (e >= 0) ? 32'd1 : 32'd0);
        checkOutput("err_idx_sticky", 32'(errIdx), (e >= 0) ? 32'(e) : 32'd0);
    endtask

    // Check the status pins at the done pulse against the model.
    task automatic checkAtDone(input bit verify);
        int e = expErrIdx(verify);
        checkOutput("done_error", 32'(error), (e >= 0) ? 32'd1 : 32'd0);
        checkOutput("done_err_idx", 32'(errIdx), (e >= 0) ? 32'(e) : 32'd0);
        checkOutput("done_busy", 32'(busy), 32'd0);
        checkOutput("done_ready", 32'(wordReady), 32'd0);
    endtask

    task automatic runRecord(input bit verify);
        @(posedge wbClk);
        #1;
        clearMon();
        applyStimulus(verify, 1'b0);
        waitDone("done_seen");
        checkAtDone(verify);
        repeat (3) @(posedge wbClk);
        #1;
        verifyBus(verify);
    endtask

    initial begin
        int n;
        wbRstN      = 1'b0;
        wordValid   = 1'b0;
        wordData    = 32'd0;
        verifyIn    = 1'b0;
        noAckIdx    = -1;
        corruptMask = 16'h0;
        clearMon();

        // Reset state
        repeat (3) @(posedge wbClk);
        @(negedge wbClk);
        checkOutput("rst_cyc", 32'(cyc), 32'd0);
        checkOutput("rst_stb", 32'(stb), 32'd0);
        checkOutput("rst_we", 32'(we), 32'd0);
        checkOutput("rst_sel", 32'(sel), 32'd0);
        checkOutput("rst_adr", adr, 32'd0);
        checkOutput("rst_dat", datOut, 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_error", 32'(error), 32'd0);
        checkOutput("rst_err_idx", 32'(errIdx), 32'd0);
        checkOutput("rst_ready", 32'(wordReady), 32'd0);
        @(posedge wbClk);
        #1;
        wbRstN = 1'b1;
        @(negedge wbClk);
        checkOutput("post_rst_ready", 32'(wordReady), 32'd1);

        // Write-only record with the incrementing pattern
        for (int i = 0; i < NUM; i++) recData[i] = 32'hA000_0000 + 32'(i);
        runRecord(1'b0);

        // Write plus clean readback with random data
        for (int i = 0; i < NUM; i++) recData[i] = $urandom;
        runRecord(1'b1);

        // Corrupted readback of words 5 and 9
        for (int i = 0; i < NUM; i++) recData[i] = $urandom;
        corruptMask = 16'h0220;
        runRecord(1'b1);

        // Missing ack on word 3 plus a random later corruption; error must clear on first word
        for (int i = 0; i < NUM; i++) recData[i] = $urandom;
        corruptMask = 16'h0;
        corruptMask[4 + $urandom_range(7)] = 1'b1;
        noAckIdx = 3;
        runRecord(1'b1);
        checkOutput("clear_error_first_word", 32'(errAfterFirst), 32'd0);
        checkOutput("clear_err_idx_first_word", 32'(errIdxAfterFirst), 32'd0);
        noAckIdx    = -1;
        corruptMask = 16'h0;

        // Reset during the write of word 6
        @(posedge wbClk);
        #1;
        clearMon();
        for (int i = 0; i < NUM; i++) recData[i] = $urandom;
        applyStimulus(1'b1, 1'b0);
        n = 0;
        @(negedge wbClk);
        while (!(stb && we && adr == BASE + 32'd24) && n < 100) begin
            @(negedge wbClk);
            n++;
        end
        checkOutput("reached_wr6", adr, BASE + 32'd24);
        wbRstN = 1'b0;
        @(negedge wbClk);
        checkOutput("midrst_cyc", 32'(cyc), 32'd0);
        checkOutput("midrst_stb", 32'(stb), 32'd0);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_ready", 32'(wordReady), 32'd0);
        @(posedge wbClk);
        #1;
        checkOutput("midrst_write_count", 32'(wAdr.size()), 32'd7);
        wbRstN = 1'b1;
        @(negedge wbClk);
        checkOutput("midrst_release_ready", 32'(wordReady), 32'd1);
        for (int i = 0; i < NUM; i++) recData[i] = $urandom;
        runRecord(1'b1);

        // Source holds valid through the whole record
        @(posedge wbClk);
        #1;
        clearMon();
        for (int i = 0; i < NUM; i++) recData[i] = $urandom;
        applyStimulus(1'b0, 1'b1);
        waitDone("hold_done_seen");
        checkOutput("hold_accept_count", 32'(acceptCnt), 32'(NUM));
        checkOutput("hold_ready_at_done", 32'(wordReady), 32'd0);
        @(negedge wbClk);
        checkOutput("hold_ready_after_done", 32'(wordReady), 32'd1);
        @(posedge wbClk);
        #1;
        wordValid = 1'b0;
        verifyBus(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", asrtCnt, failCnt);
        $finish;
    end

endmodule
